sys_cmd_seq: RTL and testbench

SYS_CMD_SEQ -- requirements
Module: sys_cmd_seq

---
 rtl/sys_pkg.sv | 33 +++
 rtl/sys_wait_timer.sv | 44 ++++
 rtl/sys_cmd_seq.sv | 218 +++++++++++++++++++++
 tb/tb_sys_cmd_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// ---------------------------------------------------------------------------
// sys_pkg
// Shared constants for the system command sequencer:
//   - command opcodes recognised in IDLE
//   - FSM state encoding
//   - register-file addresses used for ALU operands A and B
// ---------------------------------------------------------------------------
package sys_pkg;

    typedef logic [3:0] state_t;

    // Command opcodes (first byte of every command frame)
    localparam logic [7:0] CMD_WR      = 8'hAA;  // register write: addr, data
    localparam logic [7:0] CMD_RD      = 8'hBB;  // register read: addr
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // ALU with operands: A, B, fun
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // ALU without operands: fun

    // FSM state encoding
    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_WR_ADDR  = 4'd1;
    localparam state_t ST_WR_DATA  = 4'd2;
    localparam state_t ST_RD_ADDR  = 4'd3;
    localparam state_t ST_RD_WAIT  = 4'd4;
    localparam state_t ST_OP_A     = 4'd5;
    localparam state_t ST_OP_B     = 4'd6;
    localparam state_t ST_ALU_FUN  = 4'd7;
    localparam state_t ST_ALU_WAIT = 4'd8;

    // Register-file locations the ALU reads its operands from
    localparam logic [7:0] OPA_ADDR = 8'h00;
    localparam logic [7:0] OPB_ADDR = 8'h01;

endpackage

// File: rtl/sys_wait_timer.sv
// ---------------------------------------------------------------------------
// sys_wait_timer
// Bounded wait counter used while the sequencer waits for a datapath valid.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   start   : begin a new wait (counter restarts at zero)
//   clear   : abandon/finish the wait (counter stops, returns to zero)
//   expired : high during the LIMIT-th cycle of a wait
// The first cycle after start is wait cycle 1 with count 0, so expired is
// asserted in wait cycle LIMIT; the owner decides what happens on that edge.
// ---------------------------------------------------------------------------
module sys_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_reg;
    logic          running_reg;

    assign expired = running_reg && (count_reg == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (clear) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            count_reg   <= '0;
            running_reg <= 1'b1;
        end else if (running_reg && !expired) begin
            count_reg   <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/sys_cmd_seq.sv
// ---------------------------------------------------------------------------
// sys_cmd_seq
// Decodes command frames arriving as UART bytes and drives the register file
// and ALU. Every output is registered, so strobes appear one cycle after the
// byte that triggers them is accepted.
//   clk          : system clock (rising edge)
//   rst          : asynchronous active-low reset
//   RX_P_Data    : received byte, qualified by RX_D_VLD
//   RX_D_VLD     : one-cycle byte-valid strobe
//   RdData_Valid : register-file read complete
//   ALU_Valid    : ALU result complete
//   WrEn/RdEn    : register-file write/read strobes
//   Address      : register-file address (held between commands)
//   WrData       : register-file write data (held between commands)
//   ALU_EN       : ALU start strobe
//   ALU_FUN      : ALU function select (held between commands)
//   CLK_EN       : ALU clock-gate enable, high for the whole ALU operation
//   cmd_timeout  : one-cycle flag when a wait for a valid is abandoned
// ---------------------------------------------------------------------------
module sys_cmd_seq
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX_P_Data,
    input  logic                  RX_D_VLD,
    input  logic                  RdData_Valid,
    input  logic                  ALU_Valid,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_EN,
    output logic                  cmd_timeout
);

    state_t                  state_reg,    state_next;
    logic [ADDR_WIDTH-1:0]   addr_cap_reg, addr_cap_next;
    logic                    wr_en_reg,    wr_en_next;
    logic                    rd_en_reg,    rd_en_next;
    logic [ADDR_WIDTH-1:0]   address_reg,  address_next;
    logic [DATA_WIDTH-1:0]   wr_data_reg,  wr_data_next;
    logic                    alu_en_reg,   alu_en_next;
    logic [3:0]              alu_fun_reg,  alu_fun_next;
    logic                    clk_en_reg,   clk_en_next;
    logic                    timeout_reg,  timeout_next;

    logic timer_start;
    logic timer_clear;
    logic timer_expired;

    sys_wait_timer #(
        .LIMIT   (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (timer_start),
        .clear   (timer_clear),
        .expired (timer_expired)
    );

    always_comb begin
        state_next    = state_reg;
        addr_cap_next = addr_cap_reg;
        wr_en_next    = 1'b0;
        rd_en_next    = 1'b0;
        alu_en_next   = 1'b0;
        timeout_next  = 1'b0;
        clk_en_next   = clk_en_reg;
        address_next  = address_reg;
        wr_data_next  = wr_data_reg;
        alu_fun_next  = alu_fun_reg;
        timer_start   = 1'b0;
        timer_clear   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_Data)
                        DATA_WIDTH'(CMD_WR):      state_next = ST_WR_ADDR;
                        DATA_WIDTH'(CMD_RD):      state_next = ST_RD_ADDR;
                        DATA_WIDTH'(CMD_ALU_OP):  state_next = ST_OP_A;
                        DATA_WIDTH'(CMD_ALU_NOP): state_next = ST_ALU_FUN;
                        default:                  state_next = ST_IDLE;
                    endcase
                end
            end

            ST_WR_ADDR: begin
                // Captured privately so Address keeps showing the previous
                // access until the write actually happens.
                if (RX_D_VLD) begin
                    addr_cap_next = RX_P_Data[ADDR_WIDTH-1:0];
                    state_next    = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = addr_cap_reg;
                    wr_data_next = RX_P_Data;
                    state_next   = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_next   = 1'b1;
                    address_next = RX_P_Data[ADDR_WIDTH-1:0];
                    timer_start  = 1'b1;
                    state_next   = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                // Valid wins over an expiry landing in the same cycle.
                if (RdData_Valid) begin
                    timer_clear = 1'b1;
                    state_next  = ST_IDLE;
                end else if (timer_expired) begin
                    timeout_next = 1'b1;
                    timer_clear  = 1'b1;
                    state_next   = ST_IDLE;
                end
            end

            ST_OP_A: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_next = RX_P_Data;
                    state_next   = ST_OP_B;
                end
            end

            ST_OP_B: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_next = RX_P_Data;
                    state_next   = ST_ALU_FUN;
                end
            end

            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_next = RX_P_Data[3:0];
                    alu_en_next  = 1'b1;
                    clk_en_next  = 1'b1;
                    timer_start  = 1'b1;
                    state_next   = ST_ALU_WAIT;
                end
            end

            ST_ALU_WAIT: begin
                if (ALU_Valid) begin
                    clk_en_next = 1'b0;
                    timer_clear = 1'b1;
                    state_next  = ST_IDLE;
                end else if (timer_expired) begin
                    clk_en_next  = 1'b0;
                    timeout_next = 1'b1;
                    timer_clear  = 1'b1;
                    state_next   = ST_IDLE;
                end
            end

            default: begin
                clk_en_next = 1'b0;
                timer_clear = 1'b1;
                state_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            addr_cap_reg <= '0;
            wr_en_reg    <= 1'b0;
            rd_en_reg    <= 1'b0;
            address_reg  <= '0;
            wr_data_reg  <= '0;
            alu_en_reg   <= 1'b0;
            alu_fun_reg  <= '0;
            clk_en_reg   <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_cap_reg <= addr_cap_next;
            wr_en_reg    <= wr_en_next;
            rd_en_reg    <= rd_en_next;
            address_reg  <= address_next;
            wr_data_reg  <= wr_data_next;
            alu_en_reg   <= alu_en_next;
            alu_fun_reg  <= alu_fun_next;
            clk_en_reg   <= clk_en_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign WrEn        = wr_en_reg;
    assign RdEn        = rd_en_reg;
    assign Address     = address_reg;
    assign WrData      = wr_data_reg;
    assign ALU_EN      = alu_en_reg;
    assign ALU_FUN     = alu_fun_reg;
    assign CLK_EN      = clk_en_reg;
    assign cmd_timeout = timeout_reg;

endmodule

// File: tb/tb_sys_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_sys_cmd_seq
// Table of per-cycle {inputs, expected outputs} records for the basic
// commands, followed by hand-written sequences for timeouts, valid/expiry
// priority and mid-command reset.
// ---------------------------------------------------------------------------
module tb_sys_cmd_seq;

    typedef struct packed {
        logic       wr_en;
        logic       rd_en;
        logic       alu_en;
        logic       clk_en;
        logic       timeout;
        logic [3:0] addr;
        logic [7:0] wr_data;
        logic [3:0] alu_fun;
    } outs_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
        logic       rdv;
        logic       aluv;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_vld = 1'b0;
    logic       rd_valid = 1'b0;
    logic       alu_valid = 1'b0;

    logic       wr_en, rd_en, alu_en, clk_en, timeout;
    logic [3:0] address;
    logic [7:0] wr_data;
    logic [3:0] alu_fun;

    outs_t act;
    assign act = {wr_en, rd_en, alu_en, clk_en, timeout, address, wr_data, alu_fun};

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sys_cmd_seq #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .WAIT_LIMIT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_P_Data    (rx_data),
        .RX_D_VLD     (rx_vld),
        .RdData_Valid (rd_valid),
        .ALU_Valid    (alu_valid),
        .WrEn         (wr_en),
        .RdEn         (rd_en),
        .Address      (address),
        .WrData       (wr_data),
        .ALU_EN       (alu_en),
        .ALU_FUN      (alu_fun),
        .CLK_EN       (clk_en),
        .cmd_timeout  (timeout)
    );

    function automatic outs_t o(input logic w, input logic r, input logic e,
                                input logic c, input logic t, input logic [3:0] a,
                                input logic [7:0] d, input logic [3:0] f);
        outs_t x;
        x = {w, r, e, c, t, a, d, f};
        return x;
    endfunction

    function automatic string fmt(input outs_t x);
        return $sformatf("WrEn=%b RdEn=%b ALU_EN=%b CLK_EN=%b timeout=%b Addr=%h WrData=%h FUN=%h",
                         x.wr_en, x.rd_en, x.alu_en, x.clk_en, x.timeout,
                         x.addr, x.wr_data, x.alu_fun);
    endfunction

    task automatic check(input string name, input outs_t exp);
        checks++;
        if (act === exp) begin
            passed++;
            $display("%-14s ok   %s", name, fmt(act));
        end else begin
            $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic vld, input logic [7:0] d,
                        input logic rdv, input logic aluv);
        rx_vld    = vld;
        rx_data   = d;
        rd_valid  = rdv;
        alu_valid = aluv;
        @(posedge clk);
        #1;
        rx_vld    = 1'b0;
        rd_valid  = 1'b0;
        alu_valid = 1'b0;
    endtask

    vec_t vq[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- table: ignore, write, read, ALU with operands
        vq.push_back({1'b1, 8'h55, 1'b0, 1'b0, o(0,0,0,0,0, 4'h0, 8'h00, 4'h0)}); // ignored
        vq.push_back({1'b1, 8'hAA, 1'b0, 1'b0, o(0,0,0,0,0, 4'h0, 8'h00, 4'h0)});
        vq.push_back({1'b1, 8'h01, 1'b0, 1'b0, o(0,0,0,0,0, 4'h0, 8'h00, 4'h0)});
        vq.push_back({1'b1, 8'hFF, 1'b0, 1'b0, o(1,0,0,0,0, 4'h1, 8'hFF, 4'h0)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,0,0, 4'h1, 8'hFF, 4'h0)});
        vq.push_back({1'b1, 8'hAA, 1'b0, 1'b0, o(0,0,0,0,0, 4'h1, 8'hFF, 4'h0)});
        vq.push_back({1'b1, 8'h05, 1'b0, 1'b0, o(0,0,0,0,0, 4'h1, 8'hFF, 4'h0)});
        vq.push_back({1'b1, 8'h3C, 1'b0, 1'b0, o(1,0,0,0,0, 4'h5, 8'h3C, 4'h0)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,0,0, 4'h5, 8'h3C, 4'h0)});
        vq.push_back({1'b1, 8'hBB, 1'b0, 1'b0, o(0,0,0,0,0, 4'h5, 8'h3C, 4'h0)});
        vq.push_back({1'b1, 8'h07, 1'b0, 1'b0, o(0,1,0,0,0, 4'h7, 8'h3C, 4'h0)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,0,0, 4'h7, 8'h3C, 4'h0)});
        vq.push_back({1'b1, 8'hAA, 1'b0, 1'b0, o(0,0,0,0,0, 4'h7, 8'h3C, 4'h0)}); // dropped
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,0,0, 4'h7, 8'h3C, 4'h0)});
        vq.push_back({1'b0, 8'h00, 1'b1, 1'b0, o(0,0,0,0,0, 4'h7, 8'h3C, 4'h0)}); // read done
        vq.push_back({1'b1, 8'hCC, 1'b0, 1'b0, o(0,0,0,0,0, 4'h7, 8'h3C, 4'h0)});
        vq.push_back({1'b1, 8'h0A, 1'b0, 1'b0, o(1,0,0,0,0, 4'h0, 8'h0A, 4'h0)});
        vq.push_back({1'b1, 8'h0B, 1'b0, 1'b0, o(1,0,0,0,0, 4'h1, 8'h0B, 4'h0)});
        vq.push_back({1'b1, 8'h02, 1'b0, 1'b0, o(0,0,1,1,0, 4'h1, 8'h0B, 4'h2)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,1,0, 4'h1, 8'h0B, 4'h2)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,1,0, 4'h1, 8'h0B, 4'h2)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,1,0, 4'h1, 8'h0B, 4'h2)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b0, o(0,0,0,1,0, 4'h1, 8'h0B, 4'h2)});
        vq.push_back({1'b0, 8'h00, 1'b0, 1'b1, o(0,0,0,0,0, 4'h1, 8'h0B, 4'h2)}); // ALU done

        // ---------------- reset state
        #1;
        check("reset_low", o(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_rel", o(0,0,0,0,0, 4'h0, 8'h00, 4'h0));

        // ---------------- table
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].vld, vq[i].data, vq[i].rdv, vq[i].aluv);
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        // ---------------- DD,03 with no ALU_Valid: timeout after 15 cycles
        step(1'b1, 8'hDD, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        check("to_alu_start", o(0,0,1,1,0, 4'h1, 8'h0B, 4'h3));
        for (int n = 2; n <= 15; n++) begin
            step(n == 5, 8'hBB, 1'b0, 1'b0);   // byte during wait is dropped
            check($sformatf("to_alu_c%0d", n), o(0,0,0,1,0, 4'h1, 8'h0B, 4'h3));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("to_alu_flag", o(0,0,0,0,1, 4'h1, 8'h0B, 4'h3));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("to_alu_after", o(0,0,0,0,0, 4'h1, 8'h0B, 4'h3));

        // ---------------- valid in the expiry cycle wins: no timeout
        step(1'b1, 8'hDD, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        check("pri_start", o(0,0,1,1,0, 4'h1, 8'h0B, 4'h4));
        for (int n = 2; n <= 15; n++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("pri_c15", o(0,0,0,1,0, 4'h1, 8'h0B, 4'h4));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("pri_valid", o(0,0,0,0,0, 4'h1, 8'h0B, 4'h4));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("pri_after", o(0,0,0,0,0, 4'h1, 8'h0B, 4'h4));

        // ---------------- read timeout
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0);
        check("to_rd_start", o(0,1,0,0,0, 4'h2, 8'h0B, 4'h4));
        for (int n = 2; n <= 15; n++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("to_rd_c15", o(0,0,0,0,0, 4'h2, 8'h0B, 4'h4));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("to_rd_flag", o(0,0,0,0,1, 4'h2, 8'h0B, 4'h4));

        // ---------------- reset mid-command, then DD,01 runs normally
        step(1'b1, 8'hCC, 1'b0, 1'b0);
        step(1'b1, 8'h0A, 1'b0, 1'b0);
        check("rst_opa", o(1,0,0,0,0, 4'h0, 8'h0A, 4'h4));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", o(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_held", o(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
        step(1'b1, 8'hDD, 1'b0, 1'b0);
        check("rst_dd", o(0,0,0,0,0, 4'h0, 8'h00, 4'h0));
        step(1'b1, 8'h01, 1'b0, 1'b0);
        check("rst_fun", o(0,0,1,1,0, 4'h0, 8'h00, 4'h1));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_alu_done", o(0,0,0,0,0, 4'h0, 8'h00, 4'h1));
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'h09, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check("rst_idle_wr", o(1,0,0,0,0, 4'h9, 8'h77, 4'h1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
